frame_gen_sequencer: RTL and testbench

Run-control sequencer for the pattern frame generator core. Drives the core's control, geometry and last-period registers, and gates its byte stream, so output starts and stops only on whole-frame boundaries. Counts delivered frames, and applies geometry changes only between frames. Sits between the register-interface logic and the core, and passes the core's stream through to the downstream DMA/stream sink.

---
 rtl/frame_gen_sequencer.sv | 221 ++++++++++++++++++++++
 tb/tb_frame_gen_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_gen_sequencer.sv
// -----------------------------------------------------------------------------
// frame_gen_sequencer
//
// Run-control sequencer for the pattern frame generator core. It programs the
// core's control, geometry and last-period registers and gates the core's
// byte stream so that output only starts and stops on whole-frame boundaries.
// Geometry changes are applied between frames only, and delivered frames are
// counted.
//
// Optional feature macro: FRAME_GEN_SEQ_IRQ_EN adds a sticky interrupt
// (irq, cleared by irqClear). Default build has no interrupt logic.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   cmdStart, cmdStop      one-cycle run-control pulses
//   frameLimit             frames per start (0 = continuous)
//   geometryIn             [31:16] height, [15:0] width in pixels
//   lastPeriodIn           last-period value forwarded to the core
//   controlRegister        to core: bit0 enable, bit1 clear
//   heightWidthRegister    to core: latched geometry
//   dataOutLastPeriod      to core: latched last period
//   coreData/Valid/Last    core output stream
//   coreReady              ready back to the core (gated)
//   mData/mValid/mLast     downstream stream (gated valid)
//   mSof                   downstream start-of-frame marker
//   mReady                 downstream ready
//   busy                   state is not IDLE
//   framesDone             frames completed since the last accepted start
//   geometryError          sticky geometry-check failure
//   seqState               IDLE=0, LOAD=1, CLEAR=2, RUN=3
//   irqClear, irq          (FRAME_GEN_SEQ_IRQ_EN only) interrupt clear / flag
// -----------------------------------------------------------------------------
module frame_gen_sequencer #(
    parameter int BYTES_PER_PIXEL = 3,
    parameter int CLEAR_CYCLES    = 2,
    parameter int FRAME_CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmdStart,
    input  logic                   cmdStop,
    input  logic [FRAME_CNT_W-1:0] frameLimit,
    input  logic [31:0]            geometryIn,
    input  logic [31:0]            lastPeriodIn,
    output logic [31:0]            controlRegister,
    output logic [31:0]            heightWidthRegister,
    output logic [31:0]            dataOutLastPeriod,
    input  logic [7:0]             coreData,
    input  logic                   coreValid,
    input  logic                   coreLast,
    output logic                   coreReady,
    output logic [7:0]             mData,
    output logic                   mValid,
    output logic                   mLast,
    output logic                   mSof,
    input  logic                   mReady,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] framesDone,
    output logic                   geometryError,
`ifdef FRAME_GEN_SEQ_IRQ_EN
    input  logic                   irqClear,
    output logic                   irq,
`endif
    output logic [2:0]             seqState
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CLEAR = 3'd2,
        RUN   = 3'd3
    } state_t;

    state_t      state;
    logic [27:0] frame_bytes;
    logic [27:0] beat_count;
    logic [3:0]  clear_cnt;
    logic        stop_pending;

    // Width and height must each lie in 1..8191.
    function automatic logic geom_valid(input logic [31:0] g);
        return (g[15:0] != 16'd0) && (g[15:0] <= 16'd8191) &&
               (g[31:16] != 16'd0) && (g[31:16] <= 16'd8191);
    endfunction

    logic                   gate;
    logic                   beat;
    logic                   frame_end;
    logic                   geom_in_ok;
    logic                   geom_changed;
    logic                   stop_now;
    logic                   limit_hit;
    logic                   geom_err_set;
    logic [FRAME_CNT_W-1:0] frames_done_next;
    logic [27:0]            frame_bytes_calc;

    // Zero-latency stream path; only the handshake is gated.
    assign gate      = (state == RUN);
    assign mData     = coreData;
    assign mLast     = coreLast;
    assign mValid    = coreValid & gate;
    assign coreReady = mReady & gate;
    assign mSof      = gate & coreValid & (beat_count == 28'd0);

    assign beat      = coreValid & coreReady;
    assign frame_end = beat & (beat_count == frame_bytes - 28'd1);

    assign geom_in_ok   = geom_valid(geometryIn);
    assign geom_changed = (geometryIn != heightWidthRegister);

    // A stop arriving on the frame-end beat itself still stops at this boundary.
    assign stop_now         = stop_pending | cmdStop;
    assign frames_done_next = (framesDone == '1) ? framesDone : framesDone + 1'b1;
    assign limit_hit        = (frameLimit != '0) && (frames_done_next == frameLimit);

    // Max 8191*8191*3 fits in 28 bits, so the product never truncates.
    assign frame_bytes_calc = 28'(heightWidthRegister[12:0]) *
                              28'(heightWidthRegister[28:16]) *
                              28'(BYTES_PER_PIXEL);

    assign geom_err_set = ((state == IDLE) & cmdStart & ~geom_in_ok) |
                          ((state == RUN) & frame_end & ~stop_now & ~limit_hit &
                           geom_changed & ~geom_in_ok);

    assign busy     = (state != IDLE);
    assign seqState = state;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            controlRegister     <= 32'd0;
            heightWidthRegister <= 32'd0;
            dataOutLastPeriod   <= 32'd0;
            frame_bytes         <= 28'd0;
            beat_count          <= 28'd0;
            clear_cnt           <= 4'd0;
            stop_pending        <= 1'b0;
            framesDone          <= '0;
            geometryError       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    controlRegister <= 32'd0;
                    if (cmdStart) begin
                        if (geom_in_ok) begin
                            heightWidthRegister <= geometryIn;
                            dataOutLastPeriod   <= lastPeriodIn;
                            framesDone          <= '0;
                            geometryError       <= 1'b0;
                            stop_pending        <= cmdStop;
                            state               <= LOAD;
                        end else begin
                            geometryError <= 1'b1;
                        end
                    end
                end

                LOAD: begin
                    frame_bytes     <= frame_bytes_calc;
                    beat_count      <= 28'd0;
                    clear_cnt       <= 4'd0;
                    controlRegister <= 32'h2;
                    state           <= CLEAR;
                end

                CLEAR: begin
                    if (clear_cnt == 4'(CLEAR_CYCLES - 1)) begin
                        controlRegister <= 32'h1;
                        state           <= RUN;
                    end else begin
                        clear_cnt <= clear_cnt + 4'd1;
                    end
                end

                RUN: begin
                    if (beat)
                        beat_count <= frame_end ? 28'd0 : beat_count + 28'd1;

                    if (frame_end) begin
                        framesDone   <= frames_done_next;
                        stop_pending <= 1'b0;
                        if (stop_now || limit_hit) begin
                            controlRegister <= 32'd0;
                            state           <= IDLE;
                        end else if (geom_changed && !geom_in_ok) begin
                            geometryError   <= 1'b1;
                            controlRegister <= 32'd0;
                            state           <= IDLE;
                        end else if (geom_changed) begin
                            // Re-latch and run LOAD/CLEAR again to re-clear the core.
                            heightWidthRegister <= geometryIn;
                            dataOutLastPeriod   <= lastPeriodIn;
                            controlRegister     <= 32'd0;
                            state               <= LOAD;
                        end
                    end else if (cmdStop) begin
                        stop_pending <= 1'b1;
                    end
                end

                default: begin
                    controlRegister <= 32'd0;
                    state           <= IDLE;
                end
            endcase
        end
    end

`ifdef FRAME_GEN_SEQ_IRQ_EN
    // Sticky interrupt; a set in the same cycle as irqClear wins.
    always_ff @(posedge clk) begin
        if (reset)
            irq <= 1'b0;
        else
            irq <= frame_end | geom_err_set | (irq & ~irqClear);
    end
`endif

endmodule

// File: tb/tb_frame_gen_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_gen_sequencer
//
// Self-checking bench for frame_gen_sequencer (default build). The bench acts
// as both the pattern core (random valid/data/last) and the downstream sink
// (ready pattern per mode). A behavioural reference model tracks the run
// phase, the bytes delivered into the current frame and the frame tally, and
// every output is compared against it each cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_frame_gen_sequencer;

    localparam int BPP = 3;
    localparam int CC  = 2;
    localparam int FW  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, cmdStart, cmdStop;
    logic [FW-1:0] frameLimit;
    logic [31:0]   geometryIn, lastPeriodIn;
    logic [31:0]   controlRegister, heightWidthRegister, dataOutLastPeriod;
    logic [7:0]    coreData, mData;
    logic          coreValid, coreLast, coreReady;
    logic          mValid, mLast, mSof, mReady;
    logic          busy, geometryError;
    logic [FW-1:0] framesDone;
    logic [2:0]    seqState;

    frame_gen_sequencer #(
        .BYTES_PER_PIXEL(BPP),
        .CLEAR_CYCLES   (CC),
        .FRAME_CNT_W    (FW)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .cmdStart           (cmdStart),
        .cmdStop            (cmdStop),
        .frameLimit         (frameLimit),
        .geometryIn         (geometryIn),
        .lastPeriodIn       (lastPeriodIn),
        .controlRegister    (controlRegister),
        .heightWidthRegister(heightWidthRegister),
        .dataOutLastPeriod  (dataOutLastPeriod),
        .coreData           (coreData),
        .coreValid          (coreValid),
        .coreLast           (coreLast),
        .coreReady          (coreReady),
        .mData              (mData),
        .mValid             (mValid),
        .mLast              (mLast),
        .mSof               (mSof),
        .mReady             (mReady),
        .busy               (busy),
        .framesDone         (framesDone),
        .geometryError      (geometryError),
        .seqState           (seqState)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 idle, 1 load, 2 clear, 3 run.
    int          m_phase;
    int          m_wait;       // clear cycles still to go
    longint      m_fb;         // bytes in the current frame
    longint      m_pos;        // bytes already delivered in the current frame
    int          m_done;
    bit          m_err, m_stop;
    logic [31:0] m_geo, m_lp;

    function automatic bit geo_ok(input logic [31:0] g);
        int w, h;
        w = int'(g[15:0]);
        h = int'(g[31:16]);
        return (w >= 1) && (w <= 8191) && (h >= 1) && (h <= 8191);
    endfunction

    task automatic model_step();
        bit accepted;
        if (reset) begin
            m_phase = 0; m_wait = 0; m_fb = 0; m_pos = 0; m_done = 0;
            m_err = 0; m_stop = 0; m_geo = 0; m_lp = 0;
            return;
        end
        case (m_phase)
            0: if (cmdStart) begin
                if (geo_ok(geometryIn)) begin
                    m_geo = geometryIn; m_lp = lastPeriodIn;
                    m_done = 0; m_err = 0; m_stop = cmdStop; m_phase = 1;
                end else begin
                    m_err = 1;
                end
            end
            1: begin
                m_fb = longint'(m_geo[15:0]) * longint'(m_geo[31:16]) * BPP;
                m_pos = 0; m_wait = CC; m_phase = 2;
            end
            2: begin
                m_wait--;
                if (m_wait == 0) m_phase = 3;
            end
            default: begin
                accepted = coreValid && mReady;
                if (accepted && m_pos == m_fb - 1) begin
                    m_pos = 0;
                    if (m_done != 65535) m_done++;
                    if (m_stop || cmdStop || (frameLimit != 0 && m_done == int'(frameLimit))) begin
                        m_phase = 0;
                    end else if (geometryIn != m_geo && !geo_ok(geometryIn)) begin
                        m_err = 1; m_phase = 0;
                    end else if (geometryIn != m_geo) begin
                        m_geo = geometryIn; m_lp = lastPeriodIn; m_phase = 1;
                    end
                    m_stop = 0;
                end else begin
                    if (accepted) m_pos++;
                    if (cmdStop) m_stop = 1;
                end
            end
        endcase
    endtask

    // ---------------- per-cycle comparison ----------------
    bit chk_en = 0;
    int obs_beats, obs_sof, clr_cycles;
    int rdy_mode;

    task automatic check_outputs();
        bit g;
        logic [31:0] exp_ctrl;
        g = (m_phase == 3);
        exp_ctrl = (m_phase == 2) ? 32'h2 : (m_phase == 3) ? 32'h1 : 32'h0;
        check("mValid",    32'(mValid),    32'(coreValid & g));
        check("coreReady", 32'(coreReady), 32'(mReady & g));
        check("mData",     32'(mData),     32'(coreData));
        check("mLast",     32'(mLast),     32'(coreLast));
        check("mSof",      32'(mSof),      32'(g & coreValid & (m_pos == 0)));
        check("seqState",  32'(seqState),  32'(m_phase));
        check("busy",      32'(busy),      32'(m_phase != 0));
        check("ctrl",      controlRegister, exp_ctrl);
        check("framesDone", 32'(framesDone), 32'(m_done));
        check("geomErr",   32'(geometryError), 32'(m_err));
        check("hwReg",     heightWidthRegister, m_geo);
        check("lastPeriod", dataOutLastPeriod, m_lp);
        if (mValid && mReady) begin
            obs_beats++;
            if (mSof) obs_sof++;
        end
        if (controlRegister == 32'h2) clr_cycles++;
    endtask

    task automatic drive_core();
        coreValid = ($urandom_range(0, 3) != 0);
        coreData  = 8'($urandom);
        coreLast  = 1'($urandom_range(0, 1));
        case (rdy_mode)
            0:       mReady = 1'b1;
            1:       mReady = ~mReady;
            default: mReady = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        if (chk_en) check_outputs();
        @(posedge clk);
        model_step();
        #1;
        cmdStart = 1'b0;
        cmdStop  = 1'b0;
        drive_core();
    endtask

    task automatic clear_stats();
        obs_beats = 0; obs_sof = 0; clr_cycles = 0;
    endtask

    task automatic start(input logic [31:0] geo, input int limit);
        geometryIn   = geo;
        frameLimit   = FW'(limit);
        lastPeriodIn = $urandom;
        cmdStart     = 1'b1;
        step();
    endtask

    task automatic run_until_idle(input int max_cycles);
        int i;
        i = 0;
        while (seqState != 3'd0 && i < max_cycles) begin
            step();
            i++;
        end
        check("idle_reached", 32'(seqState), 32'd0);
    endtask

    task automatic wait_model(input int done, input int pos, input int max_cycles);
        int i;
        i = 0;
        while (!(m_phase == 3 && m_done == done && m_pos == longint'(pos)) && i < max_cycles) begin
            step();
            i++;
        end
        check("wait_point", 32'(i < max_cycles), 32'd1);
    endtask

    logic [31:0] pool [8] = '{32'h0001_0001, 32'h0002_0004, 32'h0003_0002, 32'h0001_0003,
                              32'h0000_0002, 32'h0002_0000, 32'h2000_0001, 32'h0001_2000};

    initial begin
        reset = 1'b1; cmdStart = 1'b0; cmdStop = 1'b0; frameLimit = '0;
        geometryIn = '0; lastPeriodIn = '0; mReady = 1'b1; rdy_mode = 0;
        m_phase = 0; m_wait = 0; m_fb = 0; m_pos = 0; m_done = 0;
        m_err = 0; m_stop = 0; m_geo = 0; m_lp = 0;
        drive_core();
        clear_stats();
        step();
        chk_en = 1;
        step();
        check("rst_ctrl",  controlRegister, 32'd0);
        check("rst_ready", 32'(coreReady), 32'd0);
        reset = 1'b0;
        step();

        // Single frame, 4x2 pixels -> 24 bytes.
        clear_stats();
        start(32'h0002_0004, 1);
        run_until_idle(300);
        check("t1_beats",  32'(obs_beats), 32'd24);
        check("t1_sof",    32'(obs_sof), 32'd1);
        check("t1_frames", 32'(framesDone), 32'd1);
        step();

        // Backpressure: ready toggling every cycle.
        rdy_mode = 1;
        clear_stats();
        start(32'h0002_0004, 1);
        run_until_idle(400);
        check("t2_beats", 32'(obs_beats), 32'd24);
        rdy_mode = 0;

        // Continuous run, stop at beat 10 of frame 2.
        clear_stats();
        start(32'h0002_0004, 0);
        wait_model(1, 10, 400);
        cmdStop = 1'b1;
        run_until_idle(400);
        check("t3_beats",  32'(obs_beats), 32'd48);
        check("t3_frames", 32'(framesDone), 32'd2);

        // Geometry change during frame 1: 24 bytes, re-clear, then 6 bytes.
        clear_stats();
        start(32'h0002_0004, 0);
        wait_model(0, 5, 400);
        geometryIn = 32'h0001_0002;
        frameLimit = FW'(2);
        run_until_idle(400);
        check("t4_beats",  32'(obs_beats), 32'd30);
        check("t4_frames", 32'(framesDone), 32'd2);
        check("t4_clear",  32'(clr_cycles), 32'(2 * CC));

        // Invalid geometry starts, and the 8191 boundary.
        clear_stats();
        start(32'h0000_0004, 1);
        step(); step();
        check("t5_err",   32'(geometryError), 32'd1);
        check("t5_busy",  32'(busy), 32'd0);
        check("t5_beats", 32'(obs_beats), 32'd0);
        start(32'h2000_0001, 1);
        check("t5_err8192", 32'(geometryError), 32'd1);
        start(32'h1FFF_0001, 1);
        check("t5_ok8191", 32'(busy), 32'd1);
        check("t5_errclr", 32'(geometryError), 32'd0);

        // Reset mid-frame, then a fresh start.
        start(32'h0002_0004, 0);
        wait_model(0, 5, 400);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_state",  32'(seqState), 32'd0);
        check("t6_frames", 32'(framesDone), 32'd0);
        check("t6_ctrl",   controlRegister, 32'd0);
        check("t6_hw",     heightWidthRegister, 32'd0);
        clear_stats();
        start(32'h0002_0004, 1);
        run_until_idle(300);
        check("t6_beats", 32'(obs_beats), 32'd24);
        check("t6_sof",   32'(obs_sof), 32'd1);

        // Randomised traffic against the model.
        rdy_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                geometryIn   = pool[$urandom_range(0, 7)];
                frameLimit   = FW'($urandom_range(0, 3));
                lastPeriodIn = $urandom;
                cmdStart     = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) cmdStop = 1'b1;
            if ($urandom_range(0, 59) == 0) geometryIn = pool[$urandom_range(0, 7)];
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
